// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage initiator port: byte/half/word RAM access
// with one-cycle load latency, plus a word-only MMIO window (GPIO, cycle counter, timer).
module dmem_responder #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dmem_op,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic [15:0] gpio,
    output logic        timer_irq
);

    // mem_op_t encoding shared with the core
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] REG_GPIO     = 2'd0;
    localparam logic [1:0] REG_CYCLE_LO = 2'd1;
    localparam logic [1:0] REG_CYCLE_HI = 2'd2;
    localparam logic [1:0] REG_TIMECMP  = 2'd3;

    localparam int IDXW = $clog2(DEPTH);

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        zext
    );
        logic [31:0]        sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic [31:0]        res;
        sh  = word >> {lane, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (size)
            SZ_B:    res = zext ? {24'b0, sh[7:0]}  : 32'(b_s);
            SZ_H:    res = zext ? {16'b0, sh[15:0]} : 32'(h_s);
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0] mem [DEPTH];

    logic            is_load;
    logic            is_store;
    logic [1:0]      size;
    logic            zext;
    logic            is_mmio;
    logic [1:0]      reg_sel;
    logic [IDXW-1:0] word_idx;
    logic            misalign;
    logic            reject;
    logic            accept;
    logic            ram_we;
    logic            mmio_we;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic [31:0]     ram_rd;
    logic [31:0]     mmio_rd;
    logic            unused_addr_bits;

    logic [31:0] rdata_q,   rdata_d;
    logic        error_q,   error_d;
    logic [15:0] gpio_q,    gpio_d;
    logic [63:0] cycle_q,   cycle_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [31:0] timecmp_q, timecmp_d;
    logic        irq_q,     irq_d;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_W;
        zext     = 1'b0;
        case (dmem_op)
            OP_LB:   begin is_load = 1'b1;  size = SZ_B; end
            OP_LH:   begin is_load = 1'b1;  size = SZ_H; end
            OP_LW:   begin is_load = 1'b1;  size = SZ_W; end
            OP_LBU:  begin is_load = 1'b1;  size = SZ_B; zext = 1'b1; end
            OP_LHU:  begin is_load = 1'b1;  size = SZ_H; zext = 1'b1; end
            OP_SB:   begin is_store = 1'b1; size = SZ_B; end
            OP_SH:   begin is_store = 1'b1; size = SZ_H; end
            OP_SW:   begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    // Address decode and access legality
    assign is_mmio  = |dmem_addr[31:12];
    assign reg_sel  = dmem_addr[3:2];
    assign word_idx = dmem_addr[IDXW+1:2];
    assign misalign = ((size == SZ_H) && dmem_addr[0]) ||
                      ((size == SZ_W) && (dmem_addr[1:0] != 2'b00));
    assign reject   = (is_load || is_store) && (misalign || (is_mmio && (size != SZ_W)));
    assign accept   = (is_load || is_store) && !reject;
    assign ram_we   = accept && is_store && !is_mmio;
    assign mmio_we  = accept && is_store && is_mmio;
    assign ram_rd   = mem[word_idx];
    assign unused_addr_bits = ^dmem_addr[11:2];

    // Store data is replicated across lanes so only the byte enables steer it
    always_comb begin
        be     = 4'b1111;
        wlanes = dmem_wdata;
        case (size)
            SZ_B: begin
                be     = 4'b0001 << dmem_addr[1:0];
                wlanes = {4{dmem_wdata[7:0]}};
            end
            SZ_H: begin
                be     = dmem_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{dmem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (reg_sel)
            REG_GPIO:     mmio_rd = {16'b0, gpio_q};
            REG_CYCLE_LO: mmio_rd = cycle_q[31:0];
            REG_CYCLE_HI: mmio_rd = shadow_q;
            default:      mmio_rd = timecmp_q;
        endcase
    end

    always_comb begin
        rdata_d   = rdata_q;
        error_d   = reject;
        gpio_d    = gpio_q;
        cycle_d   = cycle_q + 64'd1;
        shadow_d  = shadow_q;
        timecmp_d = timecmp_q;
        irq_d     = irq_q || (cycle_q[31:0] == timecmp_q);

        if (accept && is_load) begin
            rdata_d = is_mmio ? mmio_rd : load_extend(ram_rd, dmem_addr[1:0], size, zext);
            // Latching the high half here makes a LO-then-HI read pair atomic
            if (is_mmio && (reg_sel == REG_CYCLE_LO)) begin
                shadow_d = cycle_q[63:32];
            end
        end else if (reject && is_load) begin
            rdata_d = '0;
        end

        if (mmio_we) begin
            case (reg_sel)
                REG_GPIO: gpio_d = dmem_wdata[15:0];
                REG_TIMECMP: begin
                    timecmp_d = dmem_wdata;
                    irq_d     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            error_q   <= 1'b0;
            gpio_q    <= '0;
            cycle_q   <= '0;
            shadow_q  <= '0;
            timecmp_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            gpio_q    <= gpio_d;
            cycle_q   <= cycle_d;
            shadow_q  <= shadow_d;
            timecmp_q <= timecmp_d;
            irq_q     <= irq_d;
        end
    end

    // RAM is not reset, but a store caught by reset must not land
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign dmem_rdata = rdata_q;
    assign dmem_error = error_q;
    assign gpio       = gpio_q;
    assign timer_irq  = irq_q;

endmodule
